prog_loader: RTL and testbench

Writer-side counterpart to the CPU's instruction fetch path. It receives a framed byte stream, assembles 16-bit instruction words (high byte first) and writes them sequentially into instruction memory. While a load is in progress it holds the CPU halted via cpu_en, and it releases the CPU only after a valid checksum. It sits between the host byte link and the InsROM write port, and drives the CPU top-level en input.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 22 ++
 rtl/ld_word_asm.sv | 40 ++++
 rtl/prog_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_loader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int             DEF_ADDR_W      = 16;
  localparam logic [15:0]    DEF_BASE_ADDR   = 16'h0000;
  localparam int             DEF_MAX_WORDS   = 256;
  localparam int             DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_DAT_LO = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-link input and instruction-memory write port of the loader.
// master = host/memory side, slave = loader side.
interface prog_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [15:0]       mem_wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/ld_word_asm.sv
// Assembles 16-bit words from hi/lo byte pairs and keeps the running XOR
// checksum of every byte it is handed.
module ld_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,        // restart checksum for a new frame
  input  logic        byte_en,    // byte accepted and part of the checksum
  input  logic        is_data,    // byte is instruction data
  input  logic        is_lo,      // data byte is the low half of a word
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [7:0]  checksum
);
  logic [7:0] hi_reg;

  // Latch high byte, emit {hi,lo} one cycle after the low byte, fold checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg     <= 8'h00;
      word       <= 16'h0000;
      word_valid <= 1'b0;
      checksum   <= 8'h00;
    end else begin
      word_valid <= 1'b0;
      if (clr)
        checksum <= 8'h00;
      else if (byte_en)
        checksum <= checksum ^ byte_in;
      if (byte_en && is_data) begin
        if (is_lo) begin
          word       <= {hi_reg, byte_in};
          word_valid <= 1'b1;
        end else begin
          hi_reg <= byte_in;
        end
      end
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, CNT_HI, CNT_LO, CNT hi/lo word
// pairs, CHK. Writes words sequentially from BASE_ADDR and holds the CPU
// halted until a frame completes with a matching checksum.
// Optional: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC
// cycles without an accepted byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                MAX_WORDS   = DEF_MAX_WORDS,
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus,
  output logic          cpu_en,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t            state_reg;
  logic              rdy_reg;
  logic [7:0]        cnt_hi_reg;
  logic [15:0]       count_reg;
  logic [15:0]       word_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              accept;
  logic [15:0]       count_now;
  logic              sync_hit;
  logic              asm_byte_en;
  logic              asm_is_data;
  logic              asm_is_lo;
  logic [15:0]       asm_word;
  logic              asm_word_valid;
  logic [7:0]        asm_checksum;
  logic              timeout;

  assign accept      = bus.rx_valid && rdy_reg;
  assign count_now   = {cnt_hi_reg, bus.rx_data};
  assign sync_hit    = accept && (bus.rx_data == SYNC_BYTE) &&
                       (state_reg == ST_IDLE || state_reg == ST_DONE ||
                        state_reg == ST_ERR);
  assign asm_is_data = (state_reg == ST_DAT_HI) || (state_reg == ST_DAT_LO);
  assign asm_is_lo   = (state_reg == ST_DAT_LO);
  assign asm_byte_en = accept && (asm_is_data || state_reg == ST_CNT_HI ||
                                  state_reg == ST_CNT_LO);

  assign bus.rx_ready    = rdy_reg;
  assign bus.mem_wr_en   = asm_word_valid;
  assign bus.mem_wr_data = asm_word;
  assign bus.mem_wr_addr = addr_reg;

  ld_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (sync_hit),
    .byte_en    (asm_byte_en),
    .is_data    (asm_is_data),
    .is_lo      (asm_is_lo),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_word_valid),
    .checksum   (asm_checksum)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            in_frame;

  assign in_frame = (state_reg == ST_CNT_HI) || (state_reg == ST_CNT_LO) ||
                    (state_reg == ST_DAT_HI) || (state_reg == ST_DAT_LO) ||
                    (state_reg == ST_CHK);
  assign timeout  = in_frame && !accept &&
                    (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  // Count idle cycles inside a frame; any accepted byte restarts the count
  always_ff @(posedge clk) begin
    if (rst || accept || !in_frame)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 1'b1;
  end
`else
  // Constant 0: without the timeout the loader waits forever in any state
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Ready is low only while reset is held
  always_ff @(posedge clk) begin
    if (rst)
      rdy_reg <= 1'b0;
    else
      rdy_reg <= 1'b1;
  end

  // Frame FSM, word counting, address sequencing and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_hi_reg   <= 8'h00;
      count_reg    <= 16'h0000;
      word_cnt_reg <= 16'h0000;
      addr_reg     <= BASE_ADDR;
      cpu_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (asm_word_valid)
        addr_reg <= addr_reg + 1'b1;
      if (timeout) begin
        state_reg <= ST_ERR;
        err       <= 1'b1;
        busy      <= 1'b0;
        cpu_en    <= 1'b0;
      end else if (accept) begin
        case (state_reg)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state_reg    <= ST_CNT_HI;
              done         <= 1'b0;
              err          <= 1'b0;
              busy         <= 1'b1;
              cpu_en       <= 1'b0;
              addr_reg     <= BASE_ADDR;
              word_cnt_reg <= 16'h0000;
            end
          end
          ST_CNT_HI: begin
            cnt_hi_reg <= bus.rx_data;
            state_reg  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            count_reg <= count_now;
            if (32'(count_now) > 32'(MAX_WORDS)) begin
              state_reg <= ST_ERR;
              err       <= 1'b1;
              busy      <= 1'b0;
              cpu_en    <= 1'b0;
            end else if (count_now == 16'h0000) begin
              state_reg <= ST_CHK;
            end else begin
              state_reg <= ST_DAT_HI;
            end
          end
          ST_DAT_HI: state_reg <= ST_DAT_LO;
          ST_DAT_LO: begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
            if (word_cnt_reg + 16'd1 == count_reg)
              state_reg <= ST_CHK;
            else
              state_reg <= ST_DAT_HI;
          end
          ST_CHK: begin
            busy <= 1'b0;
            if (bus.rx_data == asm_checksum) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              cpu_en    <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              err       <= 1'b1;
              cpu_en    <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are sent back to back, every write
// strobe is logged with the index of the byte it followed.
module tb_prog_loader;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_en, busy, done, err;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(
    .ADDR_W      (AW),
    .BASE_ADDR   (16'h0000),
    .MAX_WORDS   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .cpu_en (cpu_en),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  fr[$];
  int          n_stb;
  int          bi;
  int          stb_after [16];
  logic [15:0] stb_addr  [16];
  logic [15:0] stb_data  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called on a falling edge: a strobe seen here follows byte bi-1
  task automatic sample_strobe();
    if (bus.mem_wr_en === 1'b1) begin
      if (n_stb < 16) begin
        stb_after[n_stb] = bi - 1;
        stb_addr[n_stb]  = bus.mem_wr_addr;
        stb_data[n_stb]  = bus.mem_wr_data;
      end
      n_stb++;
    end
  endtask

  task automatic send_frame(input string name);
    n_stb = 0;
    for (int i = 0; i < fr.size(); i++) begin
      @(negedge clk);
      bi = i;
      sample_strobe();
      bus.rx_data  = fr[i];
      bus.rx_valid = 1'b1;
      check({name, "_rx_ready"}, bus.rx_ready, 1);
      @(posedge clk);
    end
    @(negedge clk);
    bi = fr.size();
    sample_strobe();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    bi = fr.size() + 1;
    sample_strobe();
    $display("frame %s: %0d bytes, %0d writes, done=%0b err=%0b busy=%0b cpu_en=%0b",
             name, fr.size(), n_stb, done, err, busy, cpu_en);
  endtask

  task automatic check_wr(input string name, input int k, input logic [15:0] addr,
                          input logic [15:0] data, input int after_idx);
    check({name, "_wr_addr"}, stb_addr[k], addr);
    check({name, "_wr_data"}, stb_data[k], data);
    check({name, "_wr_lat"},  stb_after[k], after_idx);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_ready"}, bus.rx_ready, 0);
    check({name, "_wr_en"},    bus.mem_wr_en, 0);
    check({name, "_wr_addr"},  bus.mem_wr_addr, 16'h0000);
    check({name, "_wr_data"},  bus.mem_wr_data, 16'h0000);
    check({name, "_cpu_en"},   cpu_en, 0);
    check({name, "_busy"},     busy, 0);
    check({name, "_done"},     done, 0);
    check({name, "_err"},      err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    n_stb = 0;
    bi    = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", bus.rx_ready, 1);

    // Normal frame; CHK = 00^02^12^34^AB^CD = 42
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_frame("normal");
    check("normal_n_wr", n_stb, 2);
    check_wr("normal0", 0, 16'h0000, 16'h1234, 4);
    check_wr("normal1", 1, 16'h0001, 16'hABCD, 6);
    check("normal_done", done, 1);
    check("normal_cpu_en", cpu_en, 1);
    check("normal_err", err, 0);
    check("normal_busy", busy, 0);

    // Bad checksum: writes still happen, frame fails
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
    send_frame("badchk");
    check("badchk_n_wr", n_stb, 2);
    check_wr("badchk0", 0, 16'h0000, 16'h1234, 4);
    check_wr("badchk1", 1, 16'h0001, 16'hABCD, 6);
    check("badchk_err", err, 1);
    check("badchk_done", done, 0);
    check("badchk_cpu_en", cpu_en, 0);
    check("badchk_busy", busy, 0);

    // Zero count, then garbage that must be ignored
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame("zero");
    check("zero_n_wr", n_stb, 0);
    check("zero_done", done, 1);
    check("zero_cpu_en", cpu_en, 1);
    check("zero_err", err, 0);
    fr = '{8'h11, 8'h22};
    send_frame("garbage");
    check("garbage_n_wr", n_stb, 0);
    check("garbage_done", done, 1);
    check("garbage_cpu_en", cpu_en, 1);
    check("garbage_busy", busy, 0);

    // Oversize count (MAX_WORDS = 4) then recovery; CHK = 01^DE^AD = 72
    fr = '{8'hA5, 8'h00, 8'h05};
    send_frame("oversize");
    check("oversize_n_wr", n_stb, 0);
    check("oversize_err", err, 1);
    check("oversize_busy", busy, 0);
    check("oversize_cpu_en", cpu_en, 0);
    fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'h72};
    send_frame("recover");
    check("recover_n_wr", n_stb, 1);
    check_wr("recover0", 0, 16'h0000, 16'hDEAD, 4);
    check("recover_done", done, 1);
    check("recover_err", err, 0);

    // Count exactly MAX_WORDS; CHK = 04^01^..^08 = 0C
    fr = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08, 8'h0C};
    send_frame("maxcnt");
    check("maxcnt_n_wr", n_stb, 4);
    check_wr("maxcnt0", 0, 16'h0000, 16'h0102, 4);
    check_wr("maxcnt3", 3, 16'h0003, 16'h0708, 10);
    check("maxcnt_done", done, 1);

    // SYNC bytes inside the data are plain data; CHK = 01^A5^A5 = 01
    fr = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01};
    send_frame("syncdata");
    check("syncdata_n_wr", n_stb, 1);
    check_wr("syncdata0", 0, 16'h0000, 16'hA5A5, 4);
    check("syncdata_done", done, 1);

    // Reset after the first data byte of a 2-word frame
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_frame("partial");
    check("partial_n_wr", n_stb, 0);
    check("partial_busy", busy, 1);
    check("partial_cpu_en", cpu_en, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", bus.rx_ready, 1);
    // CHK = 01^CA^FE = 35
    fr = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'h35};
    send_frame("afterrst");
    check("afterrst_n_wr", n_stb, 1);
    check_wr("afterrst0", 0, 16'h0000, 16'hCAFE, 4);
    check("afterrst_done", done, 1);

    // Stall after the high byte of a 1-word frame
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_frame("stall");
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      sample_strobe();
    end
    $display("stall: idle 20 cycles, done=%0b err=%0b busy=%0b", done, err, busy);
    check("stall_n_wr", n_stb, 0);
    check("stall_cpu_en", cpu_en, 0);
`ifdef LOADER_TIMEOUT_EN
    check("stall_err", err, 1);
    check("stall_busy", busy, 0);
`else
    check("stall_err", err, 0);
    check("stall_busy", busy, 1);
    // Frame resumes where it stopped; CHK = 01^12^34 = 27
    fr = '{8'h34, 8'h27};
    send_frame("resume");
    check("resume_n_wr", n_stb, 1);
    check_wr("resume0", 0, 16'h0000, 16'h1234, 0);
    check("resume_done", done, 1);
    check("resume_cpu_en", cpu_en, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
